regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the CPU datapath: NRD combinational read ports, two synchronous write ports (ALU writeback and long-latency/memory writeback), optional same-cycle write-to-read bypass, and a per-register busy scoreboard for outstanding long-latency writes. It sits between the ID stage (operand read, hazard check) and the WB stage, and is the generalised successor of the fixed 2-read/1-write 32×32 register file.

## Interface
- DW, 32, data width in bits
- AW, 5, register address width; NREG = 2**AW registers
- NRD, 2, number of read ports (1..4)
- ZERO_R0, 1, 1: register 0 reads 0, writes to it ignored, never busy; 0: register 0 is ordinary
- BYPASS, 1, 1: read ports see same-cycle write data; 0: read ports see stored value only
- clk  in  1  clock, all state updates on rising edge
- clrn  in  1  reset, asynchronous, active-low
- rn  in  NRD*AW  read addresses; port k = rn[k*AW +: AW]
- q  out  NRD*DW  read data; port k = q[k*DW +: DW]
- qbusy  out  NRD  busy flag of the register addressed by port k
- we0  in  1  write enable, port 0 (ALU writeback)
- wn0  in  AW  write address, port 0
- d0  in  DW  write data, port 0
- we1  in  1  write enable, port 1 (long-latency writeback)
- wn1  in  AW  write address, port 1
- d1  in  DW  write data, port 1
- bset  in  1  mark register bsn busy (long-latency op issued)
- bsn  in  AW  register to mark busy
- busy  out  NREG  full scoreboard vector, bit i = register i busy

## Operation
- State: NREG×DW data array, NREG busy bits.
- Reset (clrn=0, asynchronous): all registers 0, all busy bits 0; hence q = 0, qbusy = 0, busy = 0 while in reset and until first write/set. Reset mid-write discards the write.
- Write: on rising edge, if we0, reg[wn0] <= d0; if we1, reg[wn1] <= d1. Both enabled with wn0 == wn1: port 1 wins. ZERO_R0=1: writes to address 0 dropped.
- Read port k, BYPASS=1: if we1 && wn1==rn_k then d1; else if we0 && wn0==rn_k then d0; else reg[rn_k]. ZERO_R0=1 and rn_k==0: 0 regardless of writes. BYPASS=0: reg[rn_k] (or 0 for r0).
- Busy set: on rising edge, bset sets busy[bsn] (ignored for bsn==0 when ZERO_R0=1).
- Busy clear: on rising edge, we1 clears busy[wn1]. Port 0 writes never clear busy.
- Same register set and cleared in one cycle: set wins (new op issued as old one retires).
- bset on an already-busy register: stays busy (no counting; one outstanding op per register).
- qbusy_k = busy[rn_k]; with BYPASS=1 it is masked to 0 when we1 && wn1==rn_k && !(bset && bsn==rn_k) in the same cycle, so a consumer may use the bypassed d1.
- Address arithmetic unsigned, no wrap beyond NREG (AW bits cover all registers exactly).

## Timing
- Read latency: 0 cycles (combinational from rn, we*, wn*, d*, busy state).
- Write latency: 1 cycle; stored value visible from the cycle after the edge (BYPASS=0), same cycle (BYPASS=1).
- Busy set/clear: visible on busy/qbusy the cycle after the edge; bypass masking of qbusy is same-cycle.
- No handshake stalls: every write and bset is accepted every cycle.

## Test plan
- Reset: hold clrn=0 with we0=1 wn0=3 d0=0xFFFF_FFFF and clocks -> q all 0, busy=0; release, read r3 -> 0.
- Dual write conflict: we0=we1=1, wn0=wn1=7, d0=0x11, d1=0x22 -> after edge r7 reads 0x22; same cycle with BYPASS=1 port reading r7 -> 0x22.
- r0 protection (ZERO_R0=1): we1=1 wn1=0 d1=0x5A, bset=1 bsn=0 -> r0 reads 0, busy[0]=0.
- Scoreboard: bset bsn=9 -> next cycle busy[9]=1, qbusy for rn=9 =1; we1 wn1=9 d1=0xABCD -> same cycle qbusy=0 and q=0xABCD (BYPASS=1), next cycle busy[9]=0.
- Set/clear collision: busy[4]=1, same cycle bset bsn=4 and we1 wn1=4 -> busy[4] stays 1, qbusy for rn=4 =1.
- BYPASS=0 build: we0 wn0=2 d0=0x77, read r2 same cycle -> old value 0; next cycle -> 0x77; NRD=4 all ports read distinct registers correctly.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass and busy scoreboard
module regfile_mp #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [NRD*AW-1:0]   rn,
    output logic [NRD*DW-1:0]   q,
    output logic [NRD-1:0]      qbusy,
    input  logic                we0,
    input  logic [AW-1:0]       wn0,
    input  logic [DW-1:0]       d0,
    input  logic                we1,
    input  logic [AW-1:0]       wn1,
    input  logic [DW-1:0]       d1,
    input  logic                bset,
    input  logic [AW-1:0]       bsn,
    output logic [2**AW-1:0]    busy
);
    localparam int   NREG = 2**AW;
    localparam logic ZR   = (ZERO_R0 != 0);
    localparam logic BP   = (BYPASS != 0);

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wr0_ok;
    logic            wr1_ok;
    logic            set_ok;
    logic            byp_en;

    // Writes and busy sets aimed at a hardwired-zero r0 are dropped here
    assign wr0_ok = we0 && !(ZR && wn0 == '0);
    assign wr1_ok = we1 && !(ZR && wn1 == '0);
    assign set_ok = bset && !(ZR && bsn == '0);
    // Bypass is suppressed during reset so reads stay zero while clrn is low
    assign byp_en = BP && clrn;
    assign busy   = busy_q;

    // Next register contents: port 1 applied last so it wins an address tie
    always_comb begin
        regs_d = regs_q;
        if (wr0_ok) regs_d[wn0] = d0;
        if (wr1_ok) regs_d[wn1] = d1;
    end

    // Next scoreboard: retirement clears first so a same-cycle issue keeps it busy
    always_comb begin
        busy_d = busy_q;
        if (we1) busy_d[wn1] = 1'b0;
        if (set_ok) busy_d[bsn] = 1'b1;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit0;
        logic          hit1;
        logic          reissue;
        assign a       = rn[k*AW +: AW];
        assign hit1    = byp_en && we1 && wn1 == a;
        assign hit0    = byp_en && we0 && wn0 == a;
        assign reissue = bset && bsn == a;
        assign q[k*DW +: DW] = (ZR && a == '0) ? {DW{1'b0}} :
                               hit1 ? d1 :
                               hit0 ? d0 : regs_q[a];
        // A retiring long-latency write lets the consumer take d1 now, unless reissued
        assign qbusy[k] = busy_q[a] && !(hit1 && !reissue);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp across three parameter builds
module tb_regfile_mp;
    typedef struct {
        logic [127:0] qa;
        logic [127:0] qb;
        logic [63:0]  qc;
        logic [3:0]   ba;
        logic [3:0]   bb;
        logic [1:0]   bc;
        logic [31:0]  va;
        logic [31:0]  vc;
    } exp_t;

    logic         clk  = 1'b0;
    logic         clrn = 1'b0;
    logic [19:0]  rn   = '0;
    logic         we0  = 1'b0;
    logic         we1  = 1'b0;
    logic         bset = 1'b0;
    logic [4:0]   wn0  = '0;
    logic [4:0]   wn1  = '0;
    logic [4:0]   bsn  = '0;
    logic [31:0]  d0   = '0;
    logic [31:0]  d1   = '0;
    logic [127:0] qa;
    logic [127:0] qb;
    logic [63:0]  qc;
    logic [3:0]   qba;
    logic [3:0]   qbb;
    logic [1:0]   qbc;
    logic [31:0]  busya;
    logic [31:0]  busyb;
    logic [31:0]  busyc;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: index 1 = r0 hardwired to zero, index 0 = r0 ordinary
    logic [31:0] mem [2][32];
    bit          bz  [2][32];
    exp_t        sb  [$];

    always #5 clk = ~clk;

    regfile_mp #(.NRD(4)) u_a (
        .clk(clk), .clrn(clrn), .rn(rn), .q(qa), .qbusy(qba),
        .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
        .bset(bset), .bsn(bsn), .busy(busya));

    regfile_mp #(.NRD(4), .BYPASS(0)) u_b (
        .clk(clk), .clrn(clrn), .rn(rn), .q(qb), .qbusy(qbb),
        .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
        .bset(bset), .bsn(bsn), .busy(busyb));

    regfile_mp #(.ZERO_R0(0)) u_c (
        .clk(clk), .clrn(clrn), .rn(rn[9:0]), .q(qc), .qbusy(qbc),
        .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
        .bset(bset), .bsn(bsn), .busy(busyc));

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < 32; i++) begin
                mem[z][i] = '0;
                bz[z][i]  = 1'b0;
            end
    endtask

    // Apply the writes and busy updates that the clock edge just committed
    task automatic model_commit();
        for (int z = 0; z < 2; z++) begin
            if (we0 && !(z == 1 && wn0 == 0)) mem[z][wn0] = d0;
            if (we1 && !(z == 1 && wn1 == 0)) mem[z][wn1] = d1;
            if (we1) bz[z][wn1] = 1'b0;
            if (bset && !(z == 1 && bsn == 0)) bz[z][bsn] = 1'b1;
        end
    endtask

    function automatic logic [31:0] rd(int z, bit byp, logic [4:0] a);
        if (!clrn) return '0;
        if (z == 1 && a == 0) return '0;
        if (byp && we1 && wn1 == a) return d1;
        if (byp && we0 && wn0 == a) return d0;
        return mem[z][a];
    endfunction

    function automatic logic qbz(int z, bit byp, logic [4:0] a);
        if (!clrn) return 1'b0;
        return bz[z][a] && !(byp && we1 && wn1 == a && !(bset && bsn == a));
    endfunction

    function automatic exp_t exp_now();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.qa[k*32 +: 32] = rd(1, 1'b1, rn[k*5 +: 5]);
            e.qb[k*32 +: 32] = rd(1, 1'b0, rn[k*5 +: 5]);
            e.ba[k] = qbz(1, 1'b1, rn[k*5 +: 5]);
            e.bb[k] = qbz(1, 1'b0, rn[k*5 +: 5]);
        end
        for (int k = 0; k < 2; k++) begin
            e.qc[k*32 +: 32] = rd(0, 1'b1, rn[k*5 +: 5]);
            e.bc[k] = qbz(0, 1'b1, rn[k*5 +: 5]);
        end
        for (int i = 0; i < 32; i++) begin
            e.va[i] = bz[1][i];
            e.vc[i] = bz[0][i];
        end
        return e;
    endfunction

    task automatic step(input logic r_n, input logic w0, input logic [4:0] n0,
                        input logic [31:0] v0, input logic w1, input logic [4:0] n1,
                        input logic [31:0] v1, input logic bs, input logic [4:0] bn,
                        input logic [19:0] r);
        @(posedge clk);
        if (clrn) model_commit();
        #1;
        clrn = r_n; we0 = w0; wn0 = n0; d0 = v0;
        we1 = w1; wn1 = n1; d1 = v1; bset = bs; bsn = bn; rn = r;
        if (!clrn) model_reset();
        sb.push_back(exp_now());
    endtask

    task automatic idle(input logic [19:0] r);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, want);
        end
    endtask

    // Monitor: outputs are combinational, so each pending expectation is checked mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("q_byp", qa, e.qa);
            chk("q_nobyp", qb, e.qb);
            chk("q_r0ord", {64'd0, qc}, {64'd0, e.qc});
            chk("qbusy_byp", {124'd0, qba}, {124'd0, e.ba});
            chk("qbusy_nobyp", {124'd0, qbb}, {124'd0, e.bb});
            chk("qbusy_r0ord", {126'd0, qbc}, {126'd0, e.bc});
            chk("busy_byp", {96'd0, busya}, {96'd0, e.va});
            chk("busy_nobyp", {96'd0, busyb}, {96'd0, e.va});
            chk("busy_r0ord", {96'd0, busyc}, {96'd0, e.vc});
        end
    end

    function automatic logic [4:0] ra();
        return ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        model_reset();
        repeat (3) step(1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {4{5'd3}});
        idle({4{5'd3}});
        step(1'b1, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, {5'd7, 5'd3, 5'd7, 5'd7});
        idle({4{5'd7}});
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5A, 1'b1, 5'd0, {4{5'd0}});
        idle({4{5'd0}});
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, {4{5'd9}});
        idle({4{5'd9}});
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hABCD, 1'b0, 5'd0, {4{5'd9}});
        idle({4{5'd9}});
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, {4{5'd4}});
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, {4{5'd4}});
        idle({4{5'd4}});
        step(1'b1, 1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd2, 5'd7, 5'd9, 5'd2});
        idle({5'd2, 5'd7, 5'd9, 5'd4});
        for (int n = 0; n < 500; n++)
            step($urandom_range(0, 99) != 0,
                 1'($urandom_range(0, 1)), ra(), $urandom,
                 1'($urandom_range(0, 1)), ra(), $urandom,
                 1'($urandom_range(0, 1)), ra(),
                 {ra(), ra(), ra(), ra()});
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
